coin_acceptor: RTL and testbench

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

---
 rtl/vend_pkg.sv | 36 +++
 rtl/coin_sync.sv | 26 ++
 rtl/coin_acceptor.sv | 131 +++++++++++++
 tb/tb_coin_acceptor.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared coin codes, cent values and coin_acceptor state encoding
package vend_pkg;

    localparam logic [2:0] COIN_ZERO    = 3'b000;
    localparam logic [2:0] COIN_QUARTER = 3'b001;
    localparam logic [2:0] COIN_FIFTY   = 3'b010;
    localparam logic [2:0] COIN_DOLLAR  = 3'b100;

    localparam logic [15:0] CENTS_QUARTER = 16'd25;
    localparam logic [15:0] CENTS_FIFTY   = 16'd50;
    localparam logic [15:0] CENTS_DOLLAR  = 16'd100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_EMIT,
        ST_RELEASE
    } coin_state_t;

    function automatic logic [15:0] coin_cents(input logic [2:0] code);
        logic [15:0] v;
        v = 16'd0;
        case (code)
            COIN_QUARTER: v = CENTS_QUARTER;
            COIN_FIFTY:   v = CENTS_FIFTY;
            COIN_DOLLAR:  v = CENTS_DOLLAR;
            default:      v = 16'd0;
        endcase
        return v;
    endfunction

    function automatic logic is_valid_coin(input logic [2:0] pat);
        return (pat == COIN_QUARTER) || (pat == COIN_FIFTY) || (pat == COIN_DOLLAR);
    endfunction

endpackage

// File: rtl/coin_sync.sv
// rtl/coin_sync.sv - parameterized-width two-flop synchronizer, async active-low reset
module coin_sync #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
        end
    end

    assign dout = r_sync;

endmodule

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - debounced three-slot coin acceptor; COIN_CREDIT_TOTAL_EN adds credit_total
module coin_acceptor
    import vend_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sense_q,
    input  logic        sense_f,
    input  logic        sense_d,
    input  logic        inhibit,
    output logic [2:0]  coin,
    output logic        reject,
`ifdef COIN_CREDIT_TOTAL_EN
    output logic        busy,
    output logic [15:0] credit_total
`else
    output logic        busy
`endif
);

    localparam logic [7:0] LAST_CNT = 8'(DEBOUNCE_CYCLES - 1);

    coin_state_t r_state, w_state_d;
    logic [7:0]  r_cnt, w_cnt_d;
    logic [2:0]  r_pat, w_pat_d;
    logic [2:0]  r_coin, w_coin_d;
    logic        r_reject, w_reject_d;
    logic [2:0]  w_s;

    coin_sync #(.WIDTH(3)) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   ({sense_d, sense_f, sense_q}),
        .dout  (w_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 8'd0;
            r_pat    <= 3'b000;
            r_coin   <= COIN_ZERO;
            r_reject <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_pat    <= w_pat_d;
            r_coin   <= w_coin_d;
            r_reject <= w_reject_d;
        end
    end

    // The pulse is decided on the transition into EMIT so it is registered and
    // visible exactly during the single EMIT cycle.
    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_pat_d    = r_pat;
        w_coin_d   = COIN_ZERO;
        w_reject_d = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_s != 3'b000) begin
                    w_pat_d   = w_s;
                    w_cnt_d   = 8'd0;
                    w_state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_s == 3'b000) begin
                    w_cnt_d   = 8'd0;
                    w_state_d = ST_IDLE;
                end else if (w_s != r_pat) begin
                    w_pat_d = w_s;
                    w_cnt_d = 8'd0;
                end else if (r_cnt == LAST_CNT) begin
                    w_state_d = ST_EMIT;
                    if (is_valid_coin(r_pat) && !inhibit) begin
                        w_coin_d = r_pat;
                    end else begin
                        w_reject_d = 1'b1;
                    end
                end else begin
                    w_cnt_d = r_cnt + 8'd1;
                end
            end
            ST_EMIT: begin
                w_cnt_d   = 8'd0;
                w_state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (w_s != 3'b000) begin
                    w_cnt_d = 8'd0;
                end else if (r_cnt == LAST_CNT) begin
                    w_cnt_d   = 8'd0;
                    w_state_d = ST_IDLE;
                end else begin
                    w_cnt_d = r_cnt + 8'd1;
                end
            end
            default: begin
                w_cnt_d   = 8'd0;
                w_state_d = ST_IDLE;
            end
        endcase
    end

    assign coin   = r_coin;
    assign reject = r_reject;
    assign busy   = (r_state != ST_IDLE);

`ifdef COIN_CREDIT_TOTAL_EN
    logic [15:0] r_credit;
    logic [16:0] w_sum;

    assign w_sum = {1'b0, r_credit} + {1'b0, coin_cents(r_coin)};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_credit <= 16'd0;
        end else if (r_coin != COIN_ZERO) begin
            r_credit <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
        end
    end

    assign credit_total = r_credit;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - directed self-checking bench for coin_acceptor
module tb_coin_acceptor;

    logic        clk;
    logic        reset;
    logic        sense_q, sense_f, sense_d;
    logic        inhibit;
    logic [2:0]  coin;
    logic        reject;
    logic        busy;
`ifdef COIN_CREDIT_TOTAL_EN
    logic [15:0] credit_total;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    int edge_cnt = 0;
    int coin_cnt, rej_cnt, both_cnt;
    int coin_edge, rej_edge;
    logic [2:0] last_coin;
    int e0;

    coin_acceptor #(.DEBOUNCE_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .sense_q      (sense_q),
        .sense_f      (sense_f),
        .sense_d      (sense_d),
        .inhibit      (inhibit),
        .coin         (coin),
        .reject       (reject),
`ifdef COIN_CREDIT_TOTAL_EN
        .busy         (busy),
        .credit_total (credit_total)
`else
        .busy         (busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk) begin
        if (coin != 3'b000) begin
            coin_cnt  = coin_cnt + 1;
            last_coin = coin;
            coin_edge = edge_cnt;
        end
        if (reject) begin
            rej_cnt  = rej_cnt + 1;
            rej_edge = edge_cnt;
        end
        if (reject && coin != 3'b000) both_cnt = both_cnt + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        tests_run = tests_run + 1;
        assert (obs === exp) else begin
            tests_failed = tests_failed + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        coin_cnt  = 0;
        rej_cnt   = 0;
        both_cnt  = 0;
        coin_edge = -1;
        rej_edge  = -1;
        last_coin = 3'b000;
    endtask

    // pat = {d,f,q}; inhibit is held high for the first inh cycles of the hold
    task automatic insert(input logic [2:0] pat, input int hold, input int inh, input int tail);
        @(negedge clk);
        clear_mon();
        e0 = edge_cnt;
        {sense_d, sense_f, sense_q} = pat;
        for (int i = 0; i < hold; i++) begin
            inhibit = (i < inh);
            @(negedge clk);
        end
        inhibit = 1'b0;
        {sense_d, sense_f, sense_q} = 3'b000;
        repeat (tail) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        {sense_d, sense_f, sense_q} = 3'b000;
        inhibit = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk);
        chk("reset_coin", coin, 0);
        chk("reset_reject", reject, 0);
        chk("reset_busy", busy, 0);
`ifdef COIN_CREDIT_TOTAL_EN
        chk("reset_credit", credit_total, 0);
`endif
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // quarter held 10 cycles
        insert(3'b001, 10, 0, 15);
        chk("q_coin_count", coin_cnt, 1);
        chk("q_coin_code", last_coin, 1);
        chk("q_latency", coin_edge - e0, 7);
        chk("q_reject_count", rej_cnt, 0);
        chk("q_busy_end", busy, 0);
`ifdef COIN_CREDIT_TOTAL_EN
        chk("q_credit", credit_total, 25);
`endif

        // dollar glitch of 3 cycles
        insert(3'b100, 3, 0, 12);
        chk("glitch_coin_count", coin_cnt, 0);
        chk("glitch_reject_count", rej_cnt, 0);
        chk("glitch_busy_end", busy, 0);

        // quarter + fifty together
        insert(3'b011, 10, 0, 15);
        chk("multi_reject_count", rej_cnt, 1);
        chk("multi_coin_count", coin_cnt, 0);
        chk("multi_latency", rej_edge - e0, 7);

        // fifty with inhibit high across EMIT
        insert(3'b010, 10, 10, 15);
        chk("inh_reject_count", rej_cnt, 1);
        chk("inh_coin_count", coin_cnt, 0);
`ifdef COIN_CREDIT_TOTAL_EN
        chk("inh_credit", credit_total, 25);
`endif

        // inhibit high only early in SETTLE: dollar still credited
        insert(3'b100, 10, 3, 15);
        chk("inh_early_coin_count", coin_cnt, 1);
        chk("inh_early_coin_code", last_coin, 4);
        chk("inh_early_reject_count", rej_cnt, 0);

        // reset pulse during SETTLE with quarter held
        @(negedge clk);
        clear_mon();
        sense_q = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_busy_settle", busy, 1);
        reset = 1'b0;
        #1;
        chk("rst_busy_abort", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        e0 = edge_cnt;
        repeat (20) @(negedge clk);
        chk("rst_coin_count", coin_cnt, 1);
        chk("rst_latency", coin_edge - e0, 7);
        chk("rst_reject_count", rej_cnt, 0);
        sense_q = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_busy_end", busy, 0);

        // quarter held 50 cycles
        insert(3'b001, 50, 0, 15);
        chk("long_coin_count", coin_cnt, 1);
        chk("long_reject_count", rej_cnt, 0);
        chk("never_both", both_cnt, 0);

`ifdef COIN_CREDIT_TOTAL_EN
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("credit_cleared", credit_total, 0);
        insert(3'b100, 10, 0, 15);
        chk("credit_dollar", credit_total, 100);
        insert(3'b010, 10, 0, 15);
        insert(3'b001, 10, 0, 15);
        chk("credit_total_175", credit_total, 175);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
